// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the hazard/redirect/halt controls, the instruction
// memory request/response channel and the IF/ID pipeline register outputs of
// the fetch stage. The fetch stage connects through the master modport; the
// surrounding pipeline and memory connect through the slave modport.
interface fetch_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        halted;

  modport master (
    input  stall, redirect_valid, redirect_pc, halt_in, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr, halted
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, halt_in, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding the decode controller.
// Owns the PC, keeps at most one instruction-memory request outstanding,
// captures returned words into the IF/ID register (with a one-entry skid
// buffer for responses that arrive during a stall), and handles redirect,
// stall and halt. Redirect beats halt, halt beats normal fetch.
// Optional build macro FETCH_PERF_CNT_EN adds saturating perf counters
// perf_fetched and perf_stall_cycles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall_cycles
`endif
);

  localparam logic [1:0] ST_ISSUE  = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        halted_q, halted_d;
  logic        drop_q, drop_d;
  logic        halt_pend_q, halt_pend_d;
  logic [31:0] skid_q, skid_d;

  logic        ifid_wr_s;
  logic [31:0] ifid_wdata_s;
  logic [31:0] pc_inc_s;
  logic [31:0] redirect_tgt_s;

  assign pc_inc_s       = pc_q + 32'd4;
  assign redirect_tgt_s = bus.redirect_pc & 32'hFFFF_FFFC;

  // Next-state logic for the fetch FSM, PC, request and IF/ID register
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_d   = 1'b0;
    imem_addr_d  = imem_addr_q;
    halted_d     = halted_q;
    drop_d       = drop_q;
    halt_pend_d  = halt_pend_q;
    skid_d       = skid_q;
    ifid_wr_s    = 1'b0;
    ifid_wdata_s = 32'h0000_0000;

    case (state_q)
      ST_ISSUE: begin
        if (bus.redirect_valid) begin
          pc_d = redirect_tgt_s;
        end else if (bus.halt_in) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          imem_req_d  = 1'b1;
          imem_addr_d = pc_q;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.redirect_valid) begin
          // A response this cycle answers the old request: drop it here;
          // otherwise remember to drop it when it shows up.
          pc_d        = redirect_tgt_s;
          halt_pend_d = 1'b0;
          if (bus.imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            drop_d = 1'b1;
          end
        end else if (bus.halt_in || halt_pend_q) begin
          // Halt must still swallow the outstanding response before stopping.
          if (bus.imem_rvalid) begin
            state_d     = ST_HALTED;
            halted_d    = 1'b1;
            drop_d      = 1'b0;
            halt_pend_d = 1'b0;
          end else begin
            halt_pend_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_ISSUE;
          end else if (bus.stall) begin
            skid_d  = bus.imem_rdata;
            state_d = ST_HOLD;
          end else begin
            ifid_wr_s    = 1'b1;
            ifid_wdata_s = bus.imem_rdata;
            pc_d         = pc_inc_s;
            imem_req_d   = 1'b1;
            imem_addr_d  = pc_inc_s;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_tgt_s;
          skid_d  = 32'h0000_0000;
          state_d = ST_ISSUE;
        end else if (bus.halt_in) begin
          skid_d   = 32'h0000_0000;
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else if (!bus.stall) begin
          ifid_wr_s    = 1'b1;
          ifid_wdata_s = skid_q;
          pc_d         = pc_inc_s;
          imem_req_d   = 1'b1;
          imem_addr_d  = pc_inc_s;
          state_d      = ST_WAIT;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALTED: begin
        state_d  = ST_HALTED;
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase

    // IF/ID: flush on redirect or when halted, write on capture, hold on stall,
    // otherwise insert a bubble (PC kept for debug visibility).
    if (state_q == ST_HALTED || bus.redirect_valid) begin
      ifid_valid_d = 1'b0;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = NOP_INSTR;
    end else if (ifid_wr_s) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = pc_q;
      ifid_instr_d = ifid_wdata_s;
    end else if (bus.stall) begin
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
    end else begin
      ifid_valid_d = 1'b0;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = NOP_INSTR;
    end
  end

  // Fetch state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ISSUE;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
      halted_q     <= 1'b0;
      drop_q       <= 1'b0;
      halt_pend_q  <= 1'b0;
      skid_q       <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      halted_q     <= halted_d;
      drop_q       <= drop_d;
      halt_pend_q  <= halt_pend_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.halted     = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // Saturating performance counters, frozen once fetch has halted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= 32'h0000_0000;
      perf_stall_q   <= 32'h0000_0000;
    end else if (state_q != ST_HALTED) begin
      if (ifid_wr_s && perf_fetched_q != 32'hFFFF_FFFF) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end else begin
        perf_fetched_q <= perf_fetched_q;
      end
      if (bus.stall && perf_stall_q != 32'hFFFF_FFFF) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end else begin
        perf_stall_q <= perf_stall_q;
      end
    end else begin
      perf_fetched_q <= perf_fetched_q;
      perf_stall_q   <= perf_stall_q;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. A one-cycle-latency memory
// responder answers requests; expected request addresses and IF/ID contents
// are queued by the stimulus sequence and checked by a negedge monitor.
module tb_fetch_stage;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_ifid_q[$];
  logic [63:0] mon_e;
  logic [31:0] mon_a;
  logic        last_stall;

  fetch_stage_if bus_if();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_f;
  logic [31:0] perf_s;
  fetch_stage dut (.clk(clk), .reset(reset), .bus(bus_if),
                   .perf_fetched(perf_f), .perf_stall_cycles(perf_s));
`else
  fetch_stage dut (.clk(clk), .reset(reset), .bus(bus_if));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000)      mem_word = 32'h0050_0093;
    else if (a == 32'h0000_0004) mem_word = 32'h0000_0033;
    else                         mem_word = a ^ 32'h5A00_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ifid(input logic [31:0] pc, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (bus_if.ifid_valid === 1'b1 && bus_if.ifid_pc === pc) seen = 1'b1;
    end
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL %s: ifid_pc=%h not observed within %0d cycles", tag, pc, budget);
    end
  endtask

  // Memory model: answers each request one cycle after it is seen
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_if.imem_rvalid <= 1'b0;
      bus_if.imem_rdata  <= 32'h0000_0000;
    end else begin
      bus_if.imem_rvalid <= bus_if.imem_req;
      bus_if.imem_rdata  <= mem_word(bus_if.imem_addr);
    end
  end

  // Remember whether the last edge was stalled (IF/ID then only retained)
  always @(posedge clk or posedge reset) begin
    if (reset) last_stall <= 1'b0;
    else       last_stall <= bus_if.stall;
  end

  // Scoreboard monitor: request addresses and fresh IF/ID writes
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus_if.imem_req === 1'b1) begin
        total++;
        assert (exp_addr_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_req: observed addr=%h expected no request", bus_if.imem_addr);
        end
        if (exp_addr_q.size() != 0) begin
          mon_a = exp_addr_q.pop_front();
          chk("imem_addr", bus_if.imem_addr, mon_a);
        end
      end
      if (bus_if.ifid_valid === 1'b1 && !last_stall) begin
        total++;
        assert (exp_ifid_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_ifid: observed pc=%h expected no instruction", bus_if.ifid_pc);
        end
        if (exp_ifid_q.size() != 0) begin
          mon_e = exp_ifid_q.pop_front();
          chk("ifid_pc", bus_if.ifid_pc, mon_e[63:32]);
          chk("ifid_instr", bus_if.ifid_instr, mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    int first_cyc;
    int req_cnt;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus_if.stall          = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0000_0000;
    bus_if.halt_in        = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",    32'(bus_if.imem_req),   32'd0);
    chk("rst_addr",   bus_if.imem_addr,       32'h0000_0000);
    chk("rst_valid",  32'(bus_if.ifid_valid), 32'd0);
    chk("rst_pc",     bus_if.ifid_pc,         32'h0000_0000);
    chk("rst_instr",  bus_if.ifid_instr,      32'h0000_0013);
    chk("rst_halted", 32'(bus_if.halted),     32'd0);

    // Basic fetch of 0 and 4, then 8 under stall
    exp_addr_q.push_back(32'h0000_0000);
    exp_addr_q.push_back(32'h0000_0004);
    exp_addr_q.push_back(32'h0000_0008);
    exp_addr_q.push_back(32'h0000_000C);
    exp_ifid_q.push_back({32'h0000_0000, 32'h0050_0093});
    exp_ifid_q.push_back({32'h0000_0004, 32'h0000_0033});
    exp_ifid_q.push_back({32'h0000_0008, 32'h5A00_001B});
    reset = 1'b0;
    first_cyc = 0;
    for (int c = 1; c <= 10 && first_cyc == 0; c++) begin
      @(negedge clk);
      if (bus_if.ifid_valid === 1'b1) first_cyc = c;
    end
    chk("first_valid_cycle", 32'(first_cyc), 32'd3);
    wait_ifid(32'h0000_0004, 10, "second_fetch");

    // Stall for three cycles while the response for 8 arrives
    bus_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus_if.ifid_valid), 32'd1);
      chk("stall_pc",    bus_if.ifid_pc,         32'h0000_0004);
      chk("stall_req",   32'(bus_if.imem_req),   32'd0);
    end
    bus_if.stall = 1'b0;
    @(negedge clk);
    chk("unstall_pc",   bus_if.ifid_pc,       32'h0000_0008);
    chk("unstall_req",  32'(bus_if.imem_req), 32'd1);
    chk("unstall_addr", bus_if.imem_addr,     32'h0000_000C);

    // Redirect while waiting on the request for 12
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    bus_if.redirect_valid = 1'b0;
    chk("redir_valid", 32'(bus_if.ifid_valid), 32'd0);
    chk("redir_instr", bus_if.ifid_instr,      32'h0000_0013);
    exp_addr_q.push_back(32'h0000_0100);
    exp_addr_q.push_back(32'h0000_0104);
    exp_ifid_q.push_back({32'h0000_0100, 32'h5A00_0113});
    wait_ifid(32'h0000_0100, 12, "redir_fetch");

    // Halt with the request for 0x104 outstanding
    bus_if.halt_in = 1'b1;
    @(negedge clk);
    bus_if.halt_in = 1'b0;
    @(negedge clk);
    chk("halted", 32'(bus_if.halted), 32'd1);
    chk("halt_valid", 32'(bus_if.ifid_valid), 32'd0);
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.imem_req !== 1'b0) req_cnt++;
    end
    chk("halt_no_req", 32'(req_cnt), 32'd0);
    chk("halt_stays", 32'(bus_if.halted), 32'd1);
    chk("pre_reset_addr_q", 32'(exp_addr_q.size()), 32'd0);
    chk("pre_reset_ifid_q", 32'(exp_ifid_q.size()), 32'd0);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    chk("arst_addr",   bus_if.imem_addr,   32'h0000_0000);
    chk("arst_halted", 32'(bus_if.halted), 32'd0);
    chk("arst_req",    32'(bus_if.imem_req), 32'd0);
    chk("arst_instr",  bus_if.ifid_instr,  32'h0000_0013);
    @(negedge clk);
    @(negedge clk);

    // Redirect and halt together: redirect wins
    exp_addr_q.push_back(32'h0000_0000);
    reset = 1'b0;
    @(negedge clk);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h0000_0200;
    bus_if.halt_in        = 1'b1;
    @(negedge clk);
    bus_if.redirect_valid = 1'b0;
    bus_if.halt_in        = 1'b0;
    chk("rh_halted", 32'(bus_if.halted), 32'd0);
    exp_addr_q.push_back(32'h0000_0200);
    exp_addr_q.push_back(32'h0000_0204);
    exp_ifid_q.push_back({32'h0000_0200, 32'h5A00_0213});
    wait_ifid(32'h0000_0200, 12, "rh_fetch");
    chk("rh_halted_late", 32'(bus_if.halted), 32'd0);

    // Redirect to an unaligned top-of-memory target, then PC wraps to 0
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_if.redirect_valid = 1'b0;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    exp_addr_q.push_back(32'h0000_0004);
    exp_ifid_q.push_back({32'hFFFF_FFFC, 32'hA5FF_FFEF});
    exp_ifid_q.push_back({32'h0000_0000, 32'h0050_0093});
    wait_ifid(32'h0000_0000, 14, "wrap_fetch");
    @(posedge clk);
    #1;
    chk("end_addr_q", 32'(exp_addr_q.size()), 32'd0);
    chk("end_ifid_q", 32'(exp_ifid_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
